rom_wb_bridge: RTL
==================

Name: rom_wb_bridge

Overview:
Wishbone classic slave that lets the ao68000 32-bit bus master fetch from the 16-bit synchronous program ROM. Each 32-bit read becomes two sequential 16-bit ROM reads, high half first (68000 big-endian order). The two halves are assembled into one longword and returned with a single-cycle ACK. The ROM sits directly downstream and has one-cycle registered read latency. Writes are rejected, or optionally absorbed.

Parameters:
ROM_AW, 10, ROM word-address width (ROM depth 2^ROM_AW x 16 bits)
WRITE_ERR, 1, 1: writes terminate with ERR; 0: writes terminate with ACK and have no effect
BIG_ENDIAN, 1, 1: ROM word 2n goes to dat_o[31:16]; 0: ROM word 2n goes to dat_o[15:0]

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  30  longword address (byte address bits 31:2)
wb_sel_i  in  4  byte selects (ignored for reads)
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
rom_addr  out  ROM_AW  registered word address to the ROM
rom_data  in  16  ROM data_out (valid one clock after rom_addr is sampled)

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, rom_addr=0, hi_reg=0.
  - Reset mid-transaction abandons it; no ACK or ERR is issued.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_LO, DONE.
- req = wb_cyc_i & wb_stb_i, sampled only in IDLE.
- The word index used is wb_adr_i[ROM_AW-2:0]. Upper address bits are ignored, so the ROM aliases; decoding belongs upstream.
- Read timeline, with E0 the edge at which IDLE sees req & !wb_we_i:
  - E0: rom_addr <= {adr, 1'b0}; latch adr; state -> ADDR_HI.
  - E1: rom_addr <= {adr, 1'b1}; -> ADDR_LO.
  - E2: hi_reg <= rom_data (word 2n); -> DATA_LO.
  - E3: wb_dat_o <= {hi_reg, rom_data} (order swapped if BIG_ENDIAN=0); wb_ack_o <= 1; -> DONE.
  - E4: wb_ack_o <= 0; -> IDLE.
  - Net effect: ACK is high for exactly one cycle, in the cycle following E3.
- Write (req & wb_we_i in IDLE, at E0):
  - E0: wb_err_o <= WRITE_ERR and wb_ack_o <= !WRITE_ERR; -> DONE.
  - E1: both cleared; -> IDLE.
  - One-cycle termination. ROM and rom_addr are untouched.
- ACK and ERR are never high together. Neither is ever high outside DONE.
- wb_dat_o holds its last read value until the next read completes. It does not change on writes.
- Abort: if wb_cyc_i=0 at any edge in ADDR_HI, ADDR_LO or DATA_LO, go to IDLE next edge with no termination. rom_addr holds its value; wb_dat_o is unchanged.
- DONE always returns to IDLE; IDLE never accepts a request in the same edge DONE exits. This gives a minimum one idle cycle between transactions and prevents a stale STB being re-accepted.
- Back-to-back: a new request held after the idle cycle starts normally. Read throughput is therefore one longword per 5 cycles.
- STB deasserted with CYC held in a busy state: continue. Completion is unaffected, since the master must not drop STB before ACK.
- Address wrap: adr = max index gives rom_addr = 2^ROM_AW-2 then 2^ROM_AW-1. There is no overflow into other state.

Test Plan:
- Reset: assert reset_n=0 mid-read (during ADDR_LO) -> ack=0, err=0, dat_o=0, rom_addr=0 immediately. After release, the first read behaves normally.
- Single read, ROM model rom[i]=i, adr=0x005 -> rom_addr 0x00A at E0, 0x00B at E1; ACK for one cycle after E3; dat_o=0x000A000B. With BIG_ENDIAN=0, dat_o=0x000B000A.
- Default NOP ROM, reads at adr 0x000 and 0x1FF (wrap edge) -> dat_o=0x4E714E71 both times; rom_addr reaches 0x3FE/0x3FF; upper adr bits set (0x3FFFFE00) alias to index 0.
- Write with WRITE_ERR=1, adr=0x010, sel=4'hF -> err=1 for one cycle at E0+1, ack stays 0, rom_addr and dat_o unchanged. With WRITE_ERR=0 -> ack=1 for one cycle, err=0.
- Abort: drop CYC during DATA_LO -> no ACK or ERR; back in IDLE next cycle; a following read at adr=0x003 returns 0x00060007.
- Back-to-back reads with CYC/STB re-raised immediately after ACK -> exactly one idle cycle between transactions, 5-cycle spacing, no duplicate ACK, correct data for each.

Source files
------------

// File: rtl/rom_wb_bridge.sv
// rtl/rom_wb_bridge.sv - Wishbone classic slave assembling 32-bit reads from a 16-bit synchronous ROM
module rom_wb_bridge #(
   parameter int ROM_AW     = 10,
   parameter int WRITE_ERR  = 1,
   parameter int BIG_ENDIAN = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [29:0]       wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      DATA_LO = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                req;
   logic [ROM_AW-2:0]   adr_q;
   logic [15:0]         hi_reg;
   logic                unused_ok;

   assign req = wb_cyc_i & wb_stb_i;

   // Byte selects and upper address bits play no part: reads are always full
   // longwords and the ROM deliberately aliases across the address space.
   assign unused_ok = ^{wb_sel_i, wb_adr_i[29:ROM_AW-1]};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; dropping CYC in any busy state abandons the read silently.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = wb_we_i ? DONE : ADDR_HI;
            end
         end
         ADDR_HI: state_nxt = wb_cyc_i ? ADDR_LO : IDLE;
         ADDR_LO: state_nxt = wb_cyc_i ? DATA_LO : IDLE;
         DATA_LO: state_nxt = wb_cyc_i ? DONE : IDLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: ROM address sequencing, high-half capture, longword assembly and termination.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= 32'h0;
         rom_addr <= '0;
         adr_q    <= '0;
         hi_reg   <= 16'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (wb_we_i) begin
                     wb_err_o <= (WRITE_ERR != 0);
                     wb_ack_o <= (WRITE_ERR == 0);
                  end else begin
                     adr_q    <= wb_adr_i[ROM_AW-2:0];
                     rom_addr <= {wb_adr_i[ROM_AW-2:0], 1'b0};
                  end
               end
            end
            ADDR_HI: begin
               if (wb_cyc_i) begin
                  rom_addr <= {adr_q, 1'b1};
               end
            end
            ADDR_LO: begin
               // The ROM's one-cycle latency puts word 2n on rom_data now.
               if (wb_cyc_i) begin
                  hi_reg <= rom_data;
               end
            end
            DATA_LO: begin
               if (wb_cyc_i) begin
                  if (BIG_ENDIAN != 0) begin
                     wb_dat_o <= {hi_reg, rom_data};
                  end else begin
                     wb_dat_o <= {rom_data, hi_reg};
                  end
                  wb_ack_o <= 1'b1;
               end
            end
            DONE: begin
               wb_ack_o <= 1'b0;
               wb_err_o <= 1'b0;
            end
            default: begin
               wb_ack_o <= 1'b0;
               wb_err_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
